// File: rtl/score_bcd_counter.sv
// score_bcd_counter: frame-driven 5-digit BCD score with high score, milestone blink/hide timing (Clk50, Reset_n, frame_tick, run, restart -> score_digits, hi_digits, blink_active, blink_hide, new_hi)
module score_bcd_counter #(
  parameter int FRAMES_PER_POINT = 10,
  parameter int MILESTONE_MOD = 100,
  parameter int BLINK_FRAMES = 200,
  parameter int BLINK_PERIOD = 50
) (
  input  logic        Clk50,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        run,
  input  logic        restart,
  output logic [19:0] score_digits,
  output logic [19:0] hi_digits,
  output logic        blink_active,
  output logic        blink_hide,
  output logic        new_hi
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] OVER = 2'd2;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [1:0]    state;
  logic [19:0]   score;
  logic [19:0]   score_inc;
  logic [19:0]   milestone_val;
  logic [7:0]    frame_cnt;
  logic [BW-1:0] blink_cnt;
  logic          carry;
  logic          point;
  logic          milestone;
  always_comb begin
    carry = 1'b1;
    score_inc = score;
    for (int i = 0; i < 5; i++) begin
      score_inc[4*i +: 4] = carry ? (score[4*i +: 4] == 4'd9 ? 4'd0 : score[4*i +: 4] + 4'd1) : score[4*i +: 4];
      carry = carry && score[4*i +: 4] == 4'd9;
    end
  end
  assign point = frame_cnt == 8'(FRAMES_PER_POINT);
  assign milestone = MILESTONE_MOD == 100 && score_inc[7:0] == 8'h00 && score_inc != 20'h0;
  assign score_digits = blink_active ? milestone_val : score;
  assign blink_hide = blink_active && (32'(blink_cnt) % BLINK_PERIOD >= BLINK_PERIOD / 2);
  always_ff @(posedge Clk50 or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      score <= '0;
      hi_digits <= '0;
      milestone_val <= '0;
      frame_cnt <= 8'd1;
      blink_cnt <= '0;
      blink_active <= 1'b0;
      new_hi <= 1'b0;
    end else if (restart) begin
      state <= IDLE;
      score <= '0;
      frame_cnt <= 8'd1;
      blink_cnt <= '0;
      blink_active <= 1'b0;
      new_hi <= 1'b0;
    end else begin
      if (frame_tick && blink_active) begin
        blink_cnt <= blink_cnt == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
        blink_active <= blink_cnt != BW'(BLINK_FRAMES - 1);
      end
      case (state)
        IDLE: if (run) state <= RUN;
        RUN:
          if (!run) begin
            state <= OVER;
            if (score > hi_digits) begin
              hi_digits <= score;
              new_hi <= 1'b1;
            end
          end else if (frame_tick) begin
            frame_cnt <= point ? 8'd1 : frame_cnt + 8'd1;
            if (point) score <= score_inc;
            // a fresh milestone overrides any blink ending on the same tick
            if (point && milestone) begin
              milestone_val <= score_inc;
              blink_active <= 1'b1;
              blink_cnt <= '0;
            end
          end
        default: ;
      endcase
    end
endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Upstream score source for the on-screen score digit renderer.
- Counts frames while the game runs and keeps the current score as 5 packed BCD digits. The renderer consumes these digits directly, so it needs no divide or modulo logic.
- Keeps a high score across game-over/restart cycles.
- Generates the milestone blink and hide timing that the renderer applies to the score digits.

Parameters:
- FRAMES_PER_POINT, 10, frame ticks per score increment (legal range 1..255)
- MILESTONE_MOD, 100, score multiple that triggers blink (100 only; test = lower two digits are 00)
- BLINK_FRAMES, 200, blink duration in frame ticks
- BLINK_PERIOD, 50, hide/show period in frame ticks; hidden during the second half

Ports:
- Clk50  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-Clk50-cycle pulse per video frame, already synchronous to Clk50
- run  in  1  level, high while the game is playing
- restart  in  1  one-cycle pulse that clears the current score for a new game
- score_digits  out  20  current/displayed score; [19:16]=10^4 … [3:0]=10^0, BCD
- hi_digits  out  20  high score, BCD, same packing
- blink_active  out  1  milestone blink window in progress
- blink_hide  out  1  renderer must blank the score digits this frame
- new_hi  out  1  high score was replaced at the last game over; sticky until restart

Behaviour:
- Reset (Reset_n low, asynchronous):
  - All outputs 0; FSM to IDLE.
  - frame_cnt=1, blink_cnt=0, latched milestone value=0.
- FSM state IDLE:
  - Score held.
  - run=1 → RUN on the next edge.
- FSM state RUN:
  - Each frame_tick: if frame_cnt==FRAMES_PER_POINT, then frame_cnt←1 and the internal score increments by 1 (BCD ripple carry). Otherwise frame_cnt←frame_cnt+1.
  - The incremented score is visible one Clk50 edge after the qualifying tick.
  - run=0 → OVER.
- FSM state OVER:
  - On the entry edge: if score > hi (unsigned BCD compare), then hi_digits←score and new_hi←1.
  - Score frozen.
  - Only restart exits (to IDLE).
- restart (any state):
  - Score←0, frame_cnt←1, blink cleared, new_hi←0, state←IDLE. hi_digits is retained.
  - restart has priority over frame_tick and run in the same cycle.
  - If run is still high, RUN is entered on the following edge.
- BCD rules:
  - Each digit 0..9; a digit at 9 rolls to 0 with carry.
  - 99999+1 wraps to 00000 and does not trigger a milestone.
- Milestone:
  - Triggered when an increment produces a score with [7:0]==8'h00 and score≠0.
  - Latches the new score into milestone_val; blink_active←1; blink_cnt←0.
  - A milestone that occurs while blink_active restarts the window with the new value.
- Blink window:
  - On each frame_tick while blink_active: blink_cnt increments.
  - When blink_cnt reaches BLINK_FRAMES-1 on a tick, blink_active←0 and blink_cnt←0.
  - blink_hide = blink_active && ((blink_cnt mod BLINK_PERIOD) ≥ BLINK_PERIOD/2). Combinational from registers.
  - Blink continues frame-counting in OVER, but is cleared by restart.
- score_digits output:
  - Shows milestone_val while blink_active; otherwise the internal score.
  - The internal score keeps counting during blink.
- Simultaneous events:
  - frame_tick on the same edge run falls: the tick is ignored (state is leaving RUN).
  - Milestone and blink end on the same tick: the new window wins.

Test Plan:
- Reset_n low mid-run with score 00123 → all outputs 0 immediately; after release, IDLE with score 00000.
- run=1, 30 frame_ticks with FRAMES_PER_POINT=10 → score_digits=20'h00003; score changes exactly one edge after ticks 10/20/30.
- Preload score 00099 in RUN, 10 ticks → internal 00100; blink_active=1; score_digits=00100 for 200 ticks while the internal score reaches 00120.
  - blink_hide high for blink_cnt 25–49, 75–99, 125–149, 175–199.
  - blink_active low after tick 200.
- Score 99999, next increment → 00000; blink_active stays 0.
- Game 1 ends at 00042 (run falls) → hi=00042, new_hi=1. restart → score 0, new_hi=0, hi=00042. Game 2 ends at 00030 → hi unchanged, new_hi=0.
- restart and frame_tick asserted in the same cycle at frame_cnt=10 → score 00000, frame_cnt=1, no increment.
